// File: rtl/divider_pipe_pkg.sv
// Shared types for divider_pipe: the per-stage pipeline record and the stage-count helper.
// Record fields are sized for the widest supported build; narrower builds use the low bits.
package divider_pipe_pkg;

    localparam int unsigned MAX_W     = 64;
    localparam int unsigned MAX_TAG_W = 16;

    typedef struct packed {
        logic                 valid;
        logic [MAX_W-1:0]     rem;      // partial remainder
        logic [MAX_W-1:0]     quo;      // dividend bits shifting out, quotient bits shifting in
        logic [MAX_W-1:0]     divisor;  // divisor magnitude
        logic                 neg_q;
        logic                 neg_r;
        logic                 zero;
        logic [MAX_TAG_W-1:0] tag;
    } stage_t;

    function automatic int unsigned num_stages(input int unsigned width,
                                               input int unsigned bits_per_stage);
        return width / bits_per_stage;
    endfunction

endpackage

// File: rtl/divider_pipe_stage.sv
// One iteration stage of divider_pipe: BITS_PER_STAGE restoring shift-subtract steps, MSB first,
// optional sign correction, and a register that advances only when en is high.
module divider_pipe_stage
    import divider_pipe_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_STAGE = 2,
    parameter bit          SIGN_FIX       = 1'b0
) (
    input  logic   clk_in,
    input  logic   rst_n_in,
    input  logic   en,
    input  stage_t prev_stage,
    output stage_t this_stage
);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   trial;
    stage_t           stage_d;
    stage_t           stage_q;

    always_comb begin
        rem   = prev_stage.rem[WIDTH-1:0];
        quo   = prev_stage.quo[WIDTH-1:0];
        dvs   = prev_stage.divisor[WIDTH-1:0];
        trial = '0;
        for (int i = 0; i < int'(BITS_PER_STAGE); i++) begin
            trial = {rem, quo[WIDTH-1]};
            quo   = {quo[WIDTH-2:0], 1'b0};
            if (trial >= {1'b0, dvs}) begin
                trial  = trial - {1'b0, dvs};
                quo[0] = 1'b1;
            end
            rem = trial[WIDTH-1:0];
        end
        // Final stage folds the sign back in so the outputs come straight from this register.
        if (SIGN_FIX) begin
            if (prev_stage.neg_q) quo = -quo;
            if (prev_stage.neg_r) rem = -rem;
        end
        stage_d                = prev_stage;
        stage_d.rem            = '0;
        stage_d.quo            = '0;
        stage_d.rem[WIDTH-1:0] = rem;
        stage_d.quo[WIDTH-1:0] = quo;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stage_q <= '0;
        end else if (en) begin
            stage_q <= stage_d;
        end
    end

    assign this_stage = stage_q;

    logic unused_prev;
    assign unused_prev = ^{prev_stage.rem, prev_stage.quo, prev_stage.divisor};

endmodule

// File: rtl/divider_pipe.sv
// Pipelined restoring divider with a global-stall handshake and a sideband tag.
// Define DIVIDER_PIPE_SIGNED_EN to honour signed_in; otherwise every operation is unsigned.
module divider_pipe
    import divider_pipe_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_STAGE = 2,
    parameter int unsigned TAG_W          = 4
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    input  logic             signed_in,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             data_valid_in,
    output logic             ready_out,
    output logic [WIDTH-1:0] quotient_out,
    output logic [WIDTH-1:0] remainder_out,
    output logic [TAG_W-1:0] tag_out,
    output logic             data_valid_out,
    input  logic             ready_in,
    output logic             error_out,
    output logic             busy_out
);

    localparam int STAGES = int'(num_stages(WIDTH, BITS_PER_STAGE));

`ifdef DIVIDER_PIPE_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    if ((WIDTH % BITS_PER_STAGE) != 0) begin : g_bad_split
        $error("divider_pipe: WIDTH must be a multiple of BITS_PER_STAGE");
    end
    if (WIDTH > MAX_W || TAG_W > MAX_TAG_W || WIDTH < 2) begin : g_bad_width
        $error("divider_pipe: WIDTH or TAG_W outside the supported range");
    end

    stage_t           pipe [STAGES+1];
    stage_t           s0_d;
    stage_t           s0_q;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             a_neg;
    logic             b_neg;
    logic             div_zero;
    logic             advance;

    assign ready_out = !data_valid_out || ready_in;
    assign advance   = ready_out;
    assign div_zero  = (divisor_in == '0);

`ifdef DIVIDER_PIPE_SIGNED_EN
    always_comb begin
        a_neg = signed_in & dividend_in[WIDTH-1];
        b_neg = signed_in & divisor_in[WIDTH-1];
        a_mag = a_neg ? -dividend_in : dividend_in;
        b_mag = b_neg ? -divisor_in : divisor_in;
    end
`else
    assign a_neg = 1'b0;
    assign b_neg = 1'b0;
    assign a_mag = dividend_in;
    assign b_mag = divisor_in;

    logic unused_signed;
    assign unused_signed = signed_in;
`endif

    always_comb begin
        s0_d                    = '0;
        s0_d.valid              = data_valid_in;
        s0_d.quo[WIDTH-1:0]     = a_mag;
        s0_d.divisor[WIDTH-1:0] = b_mag;
        s0_d.zero               = div_zero;
        // A zero divisor must leave the all-ones quotient untouched by the sign fix.
        s0_d.neg_q              = (a_neg ^ b_neg) & ~div_zero;
        s0_d.neg_r              = a_neg;
        s0_d.tag[TAG_W-1:0]     = tag_in;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s0_q <= '0;
        end else if (advance) begin
            s0_q <= s0_d;
        end
    end

    assign pipe[0] = s0_q;

    for (genvar i = 1; i <= STAGES; i++) begin : g_stage
        divider_pipe_stage #(
            .WIDTH          (WIDTH),
            .BITS_PER_STAGE (BITS_PER_STAGE),
            .SIGN_FIX       (SIGNED_EN && (i == STAGES))
        ) u_stage (
            .clk_in     (clk_in),
            .rst_n_in   (rst_n_in),
            .en         (advance),
            .prev_stage (pipe[i-1]),
            .this_stage (pipe[i])
        );
    end

    stage_t last;
    assign last           = pipe[STAGES];
    assign data_valid_out = last.valid;
    assign quotient_out   = last.quo[WIDTH-1:0];
    assign remainder_out  = last.rem[WIDTH-1:0];
    assign tag_out        = last.tag[TAG_W-1:0];
    assign error_out      = last.valid & last.zero;

    always_comb begin
        busy_out = 1'b0;
        for (int i = 0; i <= STAGES; i++) begin
            busy_out = busy_out | pipe[i].valid;
        end
    end

    logic unused_last;
    assign unused_last = ^last;

endmodule

// File: tb/tb_divider_pipe.sv
// Self-checking bench for divider_pipe (WIDTH=32, BITS_PER_STAGE=2, TAG_W=4, latency 17).
module tb_divider_pipe;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [31:0] dividend_in;
    logic [31:0] divisor_in;
    logic        signed_in;
    logic [3:0]  tag_in;
    logic        data_valid_in;
    logic        ready_out;
    logic [31:0] quotient_out;
    logic [31:0] remainder_out;
    logic [3:0]  tag_out;
    logic        data_valid_out;
    logic        ready_in;
    logic        error_out;
    logic        busy_out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic [3:0]  t;
        logic        e;
    } exp_t;

    exp_t expq[$];

    always #5 clk_in = ~clk_in;

    divider_pipe #(
        .WIDTH          (32),
        .BITS_PER_STAGE (2),
        .TAG_W          (4)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .dividend_in    (dividend_in),
        .divisor_in     (divisor_in),
        .signed_in      (signed_in),
        .tag_in         (tag_in),
        .data_valid_in  (data_valid_in),
        .ready_out      (ready_out),
        .quotient_out   (quotient_out),
        .remainder_out  (remainder_out),
        .tag_out        (tag_out),
        .data_valid_out (data_valid_out),
        .ready_in       (ready_in),
        .error_out      (error_out),
        .busy_out       (busy_out)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
        end
    endtask

    // Reference division from plain integer arithmetic.
    function automatic exp_t ref_div(input logic [31:0] a, input logic [31:0] b,
                                     input logic s, input logic [3:0] t);
        exp_t x;
`ifdef DIVIDER_PIPE_SIGNED_EN
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
`endif
        x.t = t;
        x.e = (b == 32'd0);
        if (b == 32'd0) begin
            x.q = 32'hFFFF_FFFF;
            x.r = a;
        end
`ifdef DIVIDER_PIPE_SIGNED_EN
        else if (s) begin
            x.q = 32'(sa / sb);
            x.r = 32'(sa % sb);
        end
`endif
        else begin
            x.q = a / b;
            x.r = a % b;
        end
        return x;
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [3:0] t, input logic [31:0] eq, input logic [31:0] er,
                          input logic ee, input string name);
        int n;
        dividend_in   = a;
        divisor_in    = b;
        signed_in     = s;
        tag_in        = t;
        ready_in      = 1'b1;
        data_valid_in = 1'b1;
        check({name, "_ready"}, 32'(ready_out), 32'd1);
        step();
        data_valid_in = 1'b0;
        n = 1;
        while (!data_valid_out && n < 40) begin
            step();
            n++;
        end
        check({name, "_latency"}, 32'(n), 32'd17);
        check({name, "_q"}, quotient_out, eq);
        check({name, "_r"}, remainder_out, er);
        check({name, "_tag"}, 32'(tag_out), 32'(t));
        check({name, "_err"}, 32'(error_out), 32'(ee));
        step();
        check({name, "_drain"}, 32'(data_valid_out), 32'd0);
    endtask

    initial begin
        int   sent;
        int   got;
        int   cyc;
        int   seen;
        logic acc_in;
        logic acc_out;
        exp_t x;

        rst_n_in      = 1'b0;
        dividend_in   = '0;
        divisor_in    = '0;
        signed_in     = 1'b0;
        tag_in        = '0;
        data_valid_in = 1'b0;
        ready_in      = 1'b1;
        #2;
        check("rst_dv", 32'(data_valid_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_q", quotient_out, 32'd0);
        check("rst_r", remainder_out, 32'd0);
        check("rst_tag", 32'(tag_out), 32'd0);
        check("rst_err", 32'(error_out), 32'd0);
        check("rst_ready", 32'(ready_out), 32'd1);
        step();
        step();
        rst_n_in = 1'b1;
        step();

        run_op(32'd100, 32'd7, 1'b0, 4'd3, 32'd14, 32'd2, 1'b0, "u100_7");
        run_op(32'd5, 32'd9, 1'b0, 4'd5, 32'd0, 32'd5, 1'b0, "u5_9");
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, "umax_1");
        run_op(32'h1234_5678, 32'd0, 1'b0, 4'd7, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, "div0");
`ifdef DIVIDER_PIPE_SIGNED_EN
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 4'd8, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "s_m7_2");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 4'd9, 32'h8000_0000, 32'd0, 1'b0, "s_min_m1");
        run_op(32'hFFFF_FFF9, 32'd0, 1'b1, 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, "s_div0");
`else
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 4'd8, 32'h7FFF_FFFC, 32'd1, 1'b0, "nosign_m7_2");
`endif

        // Random back-to-back stream with a randomly stalling consumer.
        sent          = 0;
        got           = 0;
        cyc           = 0;
        dividend_in   = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
        divisor_in    = $urandom_range(1, 100);
        signed_in     = 1'($urandom_range(0, 1));
        tag_in        = 4'd0;
        data_valid_in = 1'b1;
        while (got < 20 && cyc < 2000) begin
            @(negedge clk_in);
            acc_in  = data_valid_in && ready_out;
            acc_out = data_valid_out && ready_in;
            if (acc_in) expq.push_back(ref_div(dividend_in, divisor_in, signed_in, tag_in));
            if (data_valid_out && expq.size() > 0) begin
                x = expq[0];
                check("rand_q", quotient_out, x.q);
                check("rand_r", remainder_out, x.r);
                check("rand_tag", 32'(tag_out), 32'(x.t));
                check("rand_err", 32'(error_out), 32'(x.e));
                if (acc_out) begin
                    void'(expq.pop_front());
                    got++;
                end
            end else if (expq.size() == 0) begin
                check("rand_spurious", 32'(data_valid_out), 32'd0);
            end
            step();
            cyc++;
            if (acc_in) begin
                sent++;
                if (sent < 20) begin
                    case ($urandom_range(0, 7))
                        0:       divisor_in = 32'd0;
                        1:       divisor_in = 32'hFFFF_FFFF;
                        2, 3:    divisor_in = $urandom_range(1, 15);
                        default: divisor_in = $urandom;
                    endcase
                    dividend_in = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
                    signed_in   = 1'($urandom_range(0, 1));
                    tag_in      = 4'(sent);
                end else begin
                    data_valid_in = 1'b0;
                end
            end
            ready_in = ($urandom_range(0, 2) != 0);
        end
        check("rand_count", 32'(got), 32'd20);
        check("rand_sent", 32'(sent), 32'd20);
        ready_in = 1'b1;
        seen     = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (data_valid_out) seen++;
        end
        check("rand_no_extra", 32'(seen), 32'd0);

        // Reset with three operations in flight.
        dividend_in   = 32'd1000;
        divisor_in    = 32'd3;
        signed_in     = 1'b0;
        data_valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tag_in = 4'(11 + i);
            step();
        end
        data_valid_in = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("pre_rst_busy", 32'(busy_out), 32'd1);
        rst_n_in = 1'b0;
        #1;
        check("mid_rst_dv", 32'(data_valid_out), 32'd0);
        check("mid_rst_busy", 32'(busy_out), 32'd0);
        check("mid_rst_q", quotient_out, 32'd0);
        check("mid_rst_r", remainder_out, 32'd0);
        check("mid_rst_tag", 32'(tag_out), 32'd0);
        check("mid_rst_err", 32'(error_out), 32'd0);
        step();
        step();
        rst_n_in = 1'b1;
        #1;
        check("post_rst_ready", 32'(ready_out), 32'd1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (data_valid_out || busy_out) seen++;
        end
        check("post_rst_stale", 32'(seen), 32'd0);
        run_op(32'd1000, 32'd3, 1'b0, 4'd14, 32'd333, 32'd1, 1'b0, "post_rst_op");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/divider_pipe.md
DIVIDER_PIPE -- requirements
Module: divider_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter BITS_PER_STAGE, default 2, quotient bits resolved per pipeline stage; WIDTH % BITS_PER_STAGE == 0, else elaboration error.
REQ-003 SHALL have parameter TAG_W, default 4, width of the sideband tag carried with each operation.
REQ-004 SHALL have port clk_in, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n_in, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports dividend_in and divisor_in, input, WIDTH each, the operands.
REQ-007 SHALL have port signed_in, input, 1, selecting signed (1) or unsigned (0) division per operation.
REQ-008 SHALL have port tag_in, input, TAG_W, a sideband tag returned unchanged with the result.
REQ-009 SHALL have ports data_valid_in (input, 1) and ready_out (output, 1), the input handshake.
REQ-010 SHALL have ports quotient_out and remainder_out, output, WIDTH each, the results.
REQ-011 SHALL have port tag_out, output, TAG_W, the tag of the operation currently at the output.
REQ-012 SHALL have ports data_valid_out (output, 1) and ready_in (input, 1), the output handshake.
REQ-013 SHALL have port error_out, output, 1, divide-by-zero flag, qualified by data_valid_out.
REQ-014 SHALL have port busy_out, output, 1, high while any pipeline stage holds a valid operation.

Function
REQ-015 SHALL define STAGES = WIDTH/BITS_PER_STAGE; latency from accept to data_valid_out is exactly STAGES+1 cycles when not stalled.
REQ-016 SHALL accept an operation on a cycle where data_valid_in && ready_out.
REQ-017 SHALL drive ready_out = !data_valid_out || ready_in (global stall); all stages advance together only when ready_out is 1.
REQ-018 SHALL hold quotient_out, remainder_out, tag_out, error_out and data_valid_out stable while data_valid_out && !ready_in.
REQ-019 SHALL accept one operation per cycle, with bubbles propagating as invalid stages, when ready_in is held high.
REQ-020 SHALL use stage 0 to register operand magnitudes, sign flags, the zero-divisor flag and the tag; each following stage performs BITS_PER_STAGE restoring shift-subtract steps, MSB first.
REQ-021 SHALL apply sign correction in the last stage before its register, so outputs come straight from flops.
REQ-022 SHALL, for unsigned division, give quotient = floor(a/b) and remainder = a - q*b.
REQ-023 SHALL, for signed division, truncate toward zero and give the remainder the sign of the dividend.
REQ-024 SHALL, for signed MIN / -1, give quotient = MIN and remainder = 0, with error_out = 0.
REQ-025 SHALL, on divisor == 0, give quotient = all ones and remainder = dividend (as presented), with error_out = 1.
REQ-026 SHALL produce outputs in acceptance order; the tag is never reordered or altered.
REQ-027 SHALL drive busy_out as the OR of all stage valid bits, ignoring data_valid_in.

Reset
REQ-028 SHALL, while rst_n_in is low, immediately clear every stage valid bit; data_valid_out=0, error_out=0, busy_out=0, quotient_out=0, remainder_out=0, tag_out=0.
REQ-029 SHALL discard in-flight operations on reset mid-operation; after release, ready_out=1 and the first accepted operation completes in STAGES+1 cycles.
REQ-030 SHALL deassert reset without a glitch on data_valid_out.

Configuration
REQ-031 SHALL, with macro DIVIDER_PIPE_SIGNED_EN defined, implement signed_in per REQ-023/REQ-024.
REQ-032 SHALL, without DIVIDER_PIPE_SIGNED_EN, keep the signed_in port but ignore it, treat all operations as unsigned, and omit the magnitude and sign-fix logic.

Structure
REQ-033 SHALL put in package divider_pipe_pkg: the stage record typedef (valid, partial remainder, quotient/dividend shift register, divisor, sign flags, zero flag, tag) and a function computing STAGES.
REQ-034 SHALL build each iteration stage as an instance of sub-module divider_pipe_stage (BITS_PER_STAGE combinational steps plus an enable-gated register), created with a generate loop.

Verification (WIDTH=32, BITS_PER_STAGE=2, latency 17)
REQ-035 SHALL cover: unsigned 100/7 tag 3 -> q=14, r=2, tag_out=3, error_out=0, exactly 17 cycles after accept.
REQ-036 SHALL cover: signed -7/2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1); signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0, error_out=0.
REQ-037 SHALL cover: 0x12345678/0 -> q=0xFFFFFFFF, r=0x12345678, error_out=1.
REQ-038 SHALL cover: 20 back-to-back random operations with ready_in toggling randomly -> every result matches the model in order, none lost or duplicated, outputs stable while stalled.
REQ-039 SHALL cover: reset asserted 5 cycles after accepting 3 operations -> outputs and busy_out go to 0 immediately; no stale result appears after release.
REQ-040 SHALL cover: with DIVIDER_PIPE_SIGNED_EN undefined, signed_in=1 with 0xFFFFFFF9/2 -> q=0x7FFFFFFC, r=1.
